// File: rtl/axis_out_row_packer.sv
// Sign-pads ROWS x Y_BITS results to power-of-two lanes and serialises them LSB slice first; 1-cycle latency, s_ready follows m_ready on the final slice.
// Optional OUT_PACK_STATS_EN adds free-running beat/packet counters.
module axis_out_row_packer #(
  parameter int ROWS              = 8,
  parameter int Y_BITS            = 24,
  parameter int M_OUTPUT_WIDTH_LF = 64
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  output logic                           s_ready,
  input  logic                           s_valid,
  input  logic [ROWS*Y_BITS-1:0]         s_data,
  input  logic                           s_last,
  input  logic                           m_ready,
  output logic                           m_valid,
  output logic [M_OUTPUT_WIDTH_LF-1:0]   m_data,
  output logic [M_OUTPUT_WIDTH_LF/8-1:0] m_keep,
  output logic                           m_last
`ifdef OUT_PACK_STATS_EN
  ,
  output logic [31:0]                    stat_beats,
  output logic [15:0]                    stat_pkts
`endif
);

  localparam int Y_BITS_PADDED = 2 ** $clog2(Y_BITS);
  localparam int HOLD_W        = ROWS * Y_BITS_PADDED;
  localparam int RATIO         = HOLD_W / M_OUTPUT_WIDTH_LF;
  localparam int SEL_W         = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(RATIO - 1);

  if ((HOLD_W % M_OUTPUT_WIDTH_LF) != 0) begin : g_bad_ratio
    $error("padded row beat width must be a multiple of M_OUTPUT_WIDTH_LF");
  end

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic [HOLD_W-1:0]  hold;
  logic               last_h;
  logic               sel_end;
  logic               m_hs;
  logic               s_hs;

  function automatic logic [HOLD_W-1:0] pad_rows(input logic [ROWS*Y_BITS-1:0] d);
    logic [HOLD_W-1:0] p;
    p = '0;
    for (int i = 0; i < ROWS; i++)
      p[i*Y_BITS_PADDED +: Y_BITS_PADDED] = Y_BITS_PADDED'(signed'(d[i*Y_BITS +: Y_BITS]));
    return p;
  endfunction

  assign sel_end = (sel == SEL_MAX);
  assign m_valid = (state == DRAIN);
  assign m_hs    = m_valid & m_ready;
  // Refill on the final slice without a bubble; costs a combinational m_ready -> s_ready path.
  assign s_ready = (state == EMPTY) | ((state == DRAIN) & sel_end & m_ready);
  assign s_hs    = s_valid & s_ready;

  // HOLD is shifted down per slice, so the current slice always sits at the bottom.
  assign m_data = hold[M_OUTPUT_WIDTH_LF-1:0];
  assign m_keep = '1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state  <= EMPTY;
      sel    <= '0;
      hold   <= '0;
      last_h <= 1'b0;
      m_last <= 1'b0;
    end else if (s_hs) begin
      state  <= DRAIN;
      sel    <= '0;
      hold   <= pad_rows(s_data);
      last_h <= s_last;
      m_last <= s_last && (RATIO == 1);
    end else if (m_hs) begin
      if (sel_end) begin
        state  <= EMPTY;
        m_last <= 1'b0;
      end else begin
        sel    <= sel + SEL_W'(1);
        hold   <= hold >> M_OUTPUT_WIDTH_LF;
        m_last <= last_h && (sel == (SEL_MAX - SEL_W'(1)));
      end
    end
  end

`ifdef OUT_PACK_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_beats <= '0;
      stat_pkts  <= '0;
    end else if (m_hs) begin
      stat_beats <= stat_beats + 32'd1;
      if (m_last)
        stat_pkts <= stat_pkts + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_out_row_packer.sv
// Directed bench for axis_out_row_packer at ROWS=8, Y_BITS=24, 64-bit output (4 slices per beat).
module tb_axis_out_row_packer;

  logic         aclk;
  logic         aresetn;
  logic         s_ready;
  logic         s_valid;
  logic [191:0] s_data;
  logic         s_last;
  logic         m_ready;
  logic         m_valid;
  logic [63:0]  m_data;
  logic [7:0]   m_keep;
  logic         m_last;
`ifdef OUT_PACK_STATS_EN
  logic [31:0]  stat_beats;
  logic [15:0]  stat_pkts;
`endif

  int tests = 0;
  int fails = 0;

  axis_out_row_packer dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .s_ready (s_ready),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_last  (s_last),
    .m_ready (m_ready),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_last  (m_last)
`ifdef OUT_PACK_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_pkts  (stat_pkts)
`endif
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  function automatic logic [255:0] tb_pad(input logic [191:0] d);
    logic [255:0] p;
    logic [23:0]  r;
    for (int i = 0; i < 8; i++) begin
      r = d[24*i +: 24];
      p[32*i +: 32] = {(r[23] ? 8'hFF : 8'h00), r};
    end
    return p;
  endfunction

  function automatic logic [191:0] mk_beat(input int k);
    logic [191:0] d;
    for (int i = 0; i < 8; i++)
      d[24*i +: 24] = 24'(k * 32'h0001_2345 + i * 32'h00A1_B2C3);
    return d;
  endfunction

  // One isolated beat: offer from idle, then expect 4 slices back-to-back and an idle cycle.
  task automatic pkt_beat(input logic [191:0] d, input logic l, input string tag);
    logic [255:0] p;
    p = tb_pad(d);
    tick(); s_valid = 1'b1; s_data = d; s_last = l; m_ready = 1'b1; #1;
    chk({tag, " s_ready idle"}, 64'(s_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick(); s_valid = 1'b0; #1;
      chk($sformatf("%s valid s%0d", tag, k), 64'(m_valid), 64'd1);
      chk($sformatf("%s data s%0d", tag, k), m_data, p[64*k +: 64]);
      chk($sformatf("%s last s%0d", tag, k), 64'(m_last), 64'(l && (k == 3)));
    end
    tick(); #1;
    chk({tag, " idle after"}, 64'(m_valid), 64'd0);
  endtask

  initial begin
    logic [191:0] d1, d3, d4;
    logic [255:0] p, p3, p4;
    int k_in, nout, lasts, rdy_pulses, first_cyc, last_cyc;

    aresetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;

    // Reset state
    tick(); tick(); #1;
    chk("rst m_valid", 64'(m_valid), 64'd0);
    chk("rst m_last", 64'(m_last), 64'd0);
    chk("rst m_data", m_data, 64'd0);
    tick(); aresetn = 1'b1; #1;
    chk("rst s_ready", 64'(s_ready), 64'd1);
    chk("rst m_keep", 64'(m_keep), 64'hFF);
`ifdef OUT_PACK_STATS_EN
    chk("rst stat_beats", 64'(stat_beats), 64'd0);
    chk("rst stat_pkts", 64'(stat_pkts), 64'd0);
`endif

    // 1: sign padding with hand-computed slices
    d1 = '0;
    d1[23:0]  = 24'h000001;
    d1[47:24] = 24'hFFFFFF;
    d1[71:48] = 24'h7FFFFF;
    d1[95:72] = 24'h800000;
    tick(); s_valid = 1'b1; s_data = d1; s_last = 1'b1; m_ready = 1'b1; #1;
    chk("pad s_ready", 64'(s_ready), 64'd1);
    chk("pad pre m_valid", 64'(m_valid), 64'd0);
    tick(); s_valid = 1'b0; #1;
    chk("pad s0 valid", 64'(m_valid), 64'd1);
    chk("pad s0 data", m_data, 64'hFFFFFFFF_00000001);
    chk("pad s0 last", 64'(m_last), 64'd0);
    tick(); #1;
    chk("pad s1 data", m_data, 64'hFF800000_007FFFFF);
    chk("pad s1 last", 64'(m_last), 64'd0);
    tick(); #1;
    chk("pad s2 data", m_data, 64'd0);
    chk("pad s2 last", 64'(m_last), 64'd0);
    tick(); #1;
    chk("pad s3 data", m_data, 64'd0);
    chk("pad s3 last", 64'(m_last), 64'd1);
    chk("pad s3 keep", 64'(m_keep), 64'hFF);
    chk("pad s3 s_ready", 64'(s_ready), 64'd1);
    tick(); #1;
    chk("pad idle", 64'(m_valid), 64'd0);

    // 2: 16 beats streamed with s_valid and m_ready held high
    k_in = 0; nout = 0; lasts = 0; rdy_pulses = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 80; c++) begin
      tick();
      s_valid = (k_in < 16); s_data = mk_beat(k_in); s_last = (k_in == 15); m_ready = 1'b1;
      #1;
      if (m_valid) begin
        p = tb_pad(mk_beat(nout / 4));
        chk($sformatf("thr data %0d", nout), m_data, p[64*(nout%4) +: 64]);
        chk($sformatf("thr last %0d", nout), 64'(m_last), 64'(nout == 63));
        if (m_last) lasts++;
        if (s_ready) rdy_pulses++;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        nout++;
      end
      if (s_valid && s_ready) k_in++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    chk("thr beats in", 64'(k_in), 64'd16);
    chk("thr outputs", 64'(nout), 64'd64);
    chk("thr span", 64'(last_cyc - first_cyc), 64'd63);
    chk("thr lasts", 64'(lasts), 64'd1);
    chk("thr s_ready pulses", 64'(rdy_pulses), 64'd16);

    // 3: backpressure mid-slice2, next beat waiting
    d3 = mk_beat(100); d4 = mk_beat(101);
    p3 = tb_pad(d3); p4 = tb_pad(d4);
    tick(); s_valid = 1'b1; s_data = d3; s_last = 1'b1; m_ready = 1'b1; #1;
    tick(); s_data = d4; #1;
    chk("bp s0 data", m_data, p3[63:0]);
    tick(); #1;
    chk("bp s1 data", m_data, p3[127:64]);
    for (int i = 0; i < 5; i++) begin
      tick(); m_ready = 1'b0; #1;
      chk($sformatf("bp hold data %0d", i), m_data, p3[191:128]);
      chk($sformatf("bp hold last %0d", i), 64'(m_last), 64'd0);
      chk($sformatf("bp hold s_ready %0d", i), 64'(s_ready), 64'd0);
      chk($sformatf("bp hold valid %0d", i), 64'(m_valid), 64'd1);
    end
    tick(); m_ready = 1'b1; #1;
    chk("bp s2 release", m_data, p3[191:128]);
    tick(); #1;
    chk("bp s3 data", m_data, p3[255:192]);
    chk("bp s3 last", 64'(m_last), 64'd1);
    chk("bp s3 s_ready", 64'(s_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick(); s_valid = 1'b0; #1;
      chk($sformatf("bp next valid %0d", k), 64'(m_valid), 64'd1);
      chk($sformatf("bp next data %0d", k), m_data, p4[64*k +: 64]);
      chk($sformatf("bp next last %0d", k), 64'(m_last), 64'(k == 3));
    end
    tick(); #1;
    chk("bp idle", 64'(m_valid), 64'd0);

    // 4: 3-cycle input gap between two beats of one packet
    p = tb_pad(mk_beat(200));
    tick(); s_valid = 1'b1; s_data = mk_beat(200); s_last = 1'b0; m_ready = 1'b1; #1;
    for (int k = 0; k < 4; k++) begin
      tick(); s_valid = 1'b0; #1;
      chk($sformatf("gap a data %0d", k), m_data, p[64*k +: 64]);
      chk($sformatf("gap a last %0d", k), 64'(m_last), 64'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) begin s_valid = 1'b1; s_data = mk_beat(201); s_last = 1'b1; end
      #1;
      chk($sformatf("gap empty %0d", i), 64'(m_valid), 64'd0);
    end
    p = tb_pad(mk_beat(201));
    for (int k = 0; k < 4; k++) begin
      tick(); s_valid = 1'b0; #1;
      chk($sformatf("gap b valid %0d", k), 64'(m_valid), 64'd1);
      chk($sformatf("gap b data %0d", k), m_data, p[64*k +: 64]);
      chk($sformatf("gap b last %0d", k), 64'(m_last), 64'(k == 3));
    end
    tick(); #1;
    chk("gap idle", 64'(m_valid), 64'd0);

    // 5: reset at SEL=2 discards the beat, next packet intact
    p = tb_pad(mk_beat(300));
    tick(); s_valid = 1'b1; s_data = mk_beat(300); s_last = 1'b1; m_ready = 1'b1; #1;
    for (int k = 0; k < 3; k++) begin
      tick(); s_valid = 1'b0; #1;
      chk($sformatf("rst mid data %0d", k), m_data, p[64*k +: 64]);
      chk($sformatf("rst mid last %0d", k), 64'(m_last), 64'd0);
    end
    aresetn = 1'b0;
    tick(); aresetn = 1'b1; #1;
    chk("rst mid m_valid", 64'(m_valid), 64'd0);
    chk("rst mid s_ready", 64'(s_ready), 64'd1);
    chk("rst mid m_last", 64'(m_last), 64'd0);
    pkt_beat(mk_beat(301), 1'b1, "rst after");

`ifdef OUT_PACK_STATS_EN
    // 6: counters over 3 packets of 2 beats
    tick(); aresetn = 1'b0;
    tick(); aresetn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      pkt_beat(mk_beat(400 + 2*n), 1'b0, "stat a");
      pkt_beat(mk_beat(401 + 2*n), 1'b1, "stat b");
    end
    #1;
    chk("stat_beats", 64'(stat_beats), 64'd24);
    chk("stat_pkts", 64'(stat_pkts), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
